// File: rtl/flash_byte_reader.sv
// rtl/flash_byte_reader.sv - single-byte SPI NOR 0x03 reader for CPU program fetch
// Optional one-entry last-byte cache enabled by defining FLASH_LAST_BYTE_CACHE_EN.
module flash_byte_reader #(
    parameter logic [23:0] BASE_ADDR    = 24'h000000,
    parameter int          CLK_DIV      = 2,
    parameter int          STARTUP_WAIT = 1000,
    parameter int          CS_HIGH_MIN  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] flashReadAddr,
    input  logic        enableFlash,
    output logic [7:0]  flashByteRead,
    output logic        flashDataReady,
    output logic        flashClk,
    output logic        flashCs,
    output logic        flashMosi,
    input  logic        flashMiso
);

    typedef enum logic [2:0] {
        STARTUP,
        IDLE,
        CMD,
        READ,
        CSH,
        HIT
    } state_t;

    localparam logic [15:0] DIV_LAST     = 16'(CLK_DIV - 1);
    localparam logic [31:0] STARTUP_LAST = 32'(STARTUP_WAIT - 1);
    localparam logic [31:0] CSH_LAST     = 32'(CS_HIGH_MIN + 1);
    localparam logic [5:0]  LAST_BIT     = 6'd39;
    localparam logic [5:0]  LAST_CMD_BIT = 6'd31;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [31:0] wait_q, wait_d;
    logic [15:0] div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [31:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  byte_q, byte_d;
    logic        ready_q, ready_d;
    logic        sck_q, sck_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;

    logic [23:0] flash_addr;
    logic [31:0] req_word;
    logic        cache_hit;

    // Address sum wraps naturally at 24 bits.
    assign flash_addr = BASE_ADDR + {13'b0, flashReadAddr};
    assign req_word   = {8'h03, flash_addr};

`ifdef FLASH_LAST_BYTE_CACHE_EN
    logic        cache_valid_q, cache_valid_d;
    logic [10:0] cache_addr_q, cache_addr_d;
    logic [7:0]  cache_byte_q, cache_byte_d;
    logic [10:0] addr_q, addr_d;

    assign cache_hit = cache_valid_q && (cache_addr_q == flashReadAddr);
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        armed_d = armed_q | ~enableFlash;
        wait_d  = wait_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        byte_d  = byte_q;
        ready_d = ready_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
`ifdef FLASH_LAST_BYTE_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_byte_d  = cache_byte_q;
        addr_d        = addr_q;
`endif

        case (state_q)
            STARTUP: begin
                ready_d = 1'b0;
                if (wait_q == STARTUP_LAST) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end

            IDLE: begin
                ready_d = 1'b1;
                if (enableFlash && armed_q) begin
                    armed_d = 1'b0;
                    ready_d = 1'b0;
`ifdef FLASH_LAST_BYTE_CACHE_EN
                    addr_d  = flashReadAddr;
`endif
                    if (cache_hit) begin
                        state_d = HIT;
                    end else begin
                        state_d = CMD;
                        cs_d    = 1'b0;
                        sck_d   = 1'b0;
                        div_d   = 16'd0;
                        bit_d   = 6'd0;
                        mosi_d  = req_word[31];
                        tx_d    = {req_word[30:0], 1'b0};
                    end
                end
            end

            CMD, READ: begin
                if (div_q == DIV_LAST) begin
                    div_d = 16'd0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        if (state_q == READ) begin
                            rx_d = {rx_q[6:0], flashMiso};
                        end
                    end else begin
                        // Falling SCK closes a bit period; next MOSI bit launches here.
                        sck_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d = CSH;
                            cs_d    = 1'b1;
                            mosi_d  = 1'b0;
                            wait_d  = 32'd0;
                        end else begin
                            bit_d  = bit_q + 6'd1;
                            mosi_d = tx_q[31];
                            tx_d   = {tx_q[30:0], 1'b0};
                            if (bit_q == LAST_CMD_BIT) begin
                                state_d = READ;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end

            CSH: begin
                cs_d  = 1'b1;
                sck_d = 1'b0;
                if (wait_q == CSH_LAST) begin
                    state_d = IDLE;
                    byte_d  = rx_q;
                    ready_d = 1'b1;
`ifdef FLASH_LAST_BYTE_CACHE_EN
                    cache_valid_d = 1'b1;
                    cache_addr_d  = addr_q;
                    cache_byte_d  = rx_q;
`endif
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end

            HIT: begin
                state_d = IDLE;
                ready_d = 1'b1;
`ifdef FLASH_LAST_BYTE_CACHE_EN
                byte_d  = cache_byte_q;
`endif
            end

            default: begin
                state_d = STARTUP;
                wait_d  = 32'd0;
                ready_d = 1'b0;
                cs_d    = 1'b1;
                sck_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STARTUP;
            armed_q <= 1'b1;
            wait_q  <= 32'd0;
            div_q   <= 16'd0;
            bit_q   <= 6'd0;
            tx_q    <= 32'd0;
            rx_q    <= 8'd0;
            byte_q  <= 8'd0;
            ready_q <= 1'b0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            wait_q  <= wait_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            byte_q  <= byte_d;
            ready_q <= ready_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

`ifdef FLASH_LAST_BYTE_CACHE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_addr_q  <= 11'd0;
            cache_byte_q  <= 8'd0;
            addr_q        <= 11'd0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_byte_q  <= cache_byte_d;
            addr_q        <= addr_d;
        end
    end
`endif

    assign flashByteRead  = byte_q;
    assign flashDataReady = ready_q;
    assign flashClk       = sck_q;
    assign flashCs        = cs_q;
    assign flashMosi      = mosi_q;

endmodule

// File: tb/tb_flash_byte_reader.sv
// tb/tb_flash_byte_reader.sv - directed bench for flash_byte_reader (two base-address instances)
module tb_flash_byte_reader;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic [10:0] addr   = 11'd0;

    logic [7:0] byte_a, byte_b;
    logic       ready_a, ready_b, sck_a, sck_b, cs_a, cs_b, mosi_a, mosi_b;
    logic       miso_a, miso_b;

    logic [7:0]  rd_a = 8'hA5;
    logic [7:0]  rd_b = 8'hA5;
    int          cnt_a = 0, cnt_b = 0, falls_a = 0, falls_b = 0;
    logic [31:0] word_a = 32'd0, word_b = 32'd0;
    logic        psck_a = 1'b0, psck_b = 1'b0, pcs_a = 1'b1, pcs_b = 1'b1;

    int n_checks = 0;
    int n_fails  = 0;
    int lat;
    int f;

    always #5 clk = ~clk;

    flash_byte_reader #(
        .BASE_ADDR(24'h100000), .CLK_DIV(1), .STARTUP_WAIT(8), .CS_HIGH_MIN(4)
    ) u_a (
        .clk(clk), .reset(reset), .flashReadAddr(addr), .enableFlash(enable),
        .flashByteRead(byte_a), .flashDataReady(ready_a), .flashClk(sck_a),
        .flashCs(cs_a), .flashMosi(mosi_a), .flashMiso(miso_a)
    );

    flash_byte_reader #(
        .BASE_ADDR(24'hFFFF00), .CLK_DIV(1), .STARTUP_WAIT(8), .CS_HIGH_MIN(4)
    ) u_b (
        .clk(clk), .reset(reset), .flashReadAddr(addr), .enableFlash(enable),
        .flashByteRead(byte_b), .flashDataReady(ready_b), .flashClk(sck_b),
        .flashCs(cs_b), .flashMosi(mosi_b), .flashMiso(miso_b)
    );

    // Flash models: count SCK rises per CS-low window, capture first 32 MOSI bits.
    assign miso_a = (cnt_a >= 32 && cnt_a < 40) ? rd_a[3'(39 - cnt_a)] : 1'b0;
    assign miso_b = (cnt_b >= 32 && cnt_b < 40) ? rd_b[3'(39 - cnt_b)] : 1'b0;

    always @(negedge clk) begin
        psck_a <= sck_a;
        pcs_a  <= cs_a;
        if (!cs_a) begin
            if (pcs_a) begin
                cnt_a   <= 0;
                falls_a <= falls_a + 1;
            end else if (sck_a && !psck_a) begin
                if (cnt_a < 32) word_a <= {word_a[30:0], mosi_a};
                cnt_a <= cnt_a + 1;
            end
        end
    end

    always @(negedge clk) begin
        psck_b <= sck_b;
        pcs_b  <= cs_b;
        if (!cs_b) begin
            if (pcs_b) begin
                cnt_b   <= 0;
                falls_b <= falls_b + 1;
            end else if (sck_b && !psck_b) begin
                if (cnt_b < 32) word_b <= {word_b[30:0], mosi_b};
                cnt_b <= cnt_b + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [10:0] a, output int l);
        addr   = a;
        enable = 1'b1;
        @(negedge clk);
        chk("ready_fall", 32'(ready_a), 32'd0);
        l = 0;
        while (ready_a !== 1'b1 && l < 300) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_cs", 32'(cs_a), 32'd1);
        chk("rst_byte", 32'(byte_a), 32'd0);
        chk("rst_sck", 32'(sck_a), 32'd0);
        chk("rst_mosi", 32'(mosi_a), 32'd0);
        reset = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("startup_ready", 32'(ready_a), 32'd0);
        end
        @(negedge clk);
        chk("startup_done", 32'(ready_a), 32'd1);
        chk("startup_cs", 32'(cs_a), 32'd1);

        // Basic read of 0x005
        rd_a = 8'hA5;
        rd_b = 8'hA5;
        do_read(11'h005, lat);
        chk("lat_005", 32'(lat), 32'd86);
        chk("byte_005", 32'(byte_a), 32'hA5);
        chk("mosi_a_005", word_a, 32'h03100005);
        chk("mosi_b_005", word_b, 32'h03FFFF05);
        chk("falls_005", 32'(falls_a), 32'd1);
        chk("cs_idle_005", 32'(cs_a), 32'd1);

        // Held-high enable must not retrigger
        f = falls_a;
        repeat (200) @(negedge clk);
        chk("hold_no_cs", 32'(falls_a), 32'(f));
        chk("hold_ready", 32'(ready_a), 32'd1);
        chk("hold_byte", 32'(byte_a), 32'hA5);

        // Address wrap on instance b
        enable = 1'b0;
        @(negedge clk);
        rd_a = 8'h5A;
        rd_b = 8'hC3;
        do_read(11'h7FF, lat);
        chk("lat_7ff", 32'(lat), 32'd86);
        chk("mosi_b_wrap", word_b, 32'h030006FF);
        chk("mosi_a_7ff", word_a, 32'h031007FF);
        chk("byte_a_7ff", 32'(byte_a), 32'h5A);
        chk("byte_b_7ff", 32'(byte_b), 32'hC3);

        // Reset in the middle of the command phase
        enable = 1'b0;
        @(negedge clk);
        addr   = 11'h005;
        enable = 1'b1;
        @(negedge clk);
        repeat (19) @(negedge clk);
        chk("cmd_cs_low", 32'(cs_a), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cs", 32'(cs_a), 32'd1);
        chk("abort_sck", 32'(sck_a), 32'd0);
        chk("abort_ready", 32'(ready_a), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (9) @(negedge clk);
        chk("restart_ready", 32'(ready_a), 32'd1);
        rd_a = 8'h96;
        do_read(11'h005, lat);
        chk("lat_restart", 32'(lat), 32'd86);
        chk("byte_restart", 32'(byte_a), 32'h96);
        chk("mosi_restart", word_a, 32'h03100005);

        // Repeated address: cache hit when enabled, full SPI otherwise
        enable = 1'b0;
        @(negedge clk);
        rd_a = 8'h3C;
        rd_b = 8'h3C;
        f = falls_a;
        do_read(11'h010, lat);
        chk("lat_010_first", 32'(lat), 32'd86);
        chk("byte_010_first", 32'(byte_a), 32'h3C);
        chk("falls_010_first", 32'(falls_a), 32'(f + 1));
        enable = 1'b0;
        @(negedge clk);
        f = falls_a;
        do_read(11'h010, lat);
`ifdef FLASH_LAST_BYTE_CACHE_EN
        chk("lat_010_hit", 32'(lat), 32'd1);
        chk("falls_010_hit", 32'(falls_a), 32'(f));
`else
        chk("lat_010_second", 32'(lat), 32'd86);
        chk("falls_010_second", 32'(falls_a), 32'(f + 1));
`endif
        chk("byte_010_second", 32'(byte_a), 32'h3C);
        chk("cs_010_second", 32'(cs_a), 32'd1);

        enable = 1'b0;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
